// File: rtl/uart_echo_display_ctrl.sv
// UART echo/display glue: RX bytes queue in a FIFO and replay to a busy-aware TX,
// while a nibble history feeds hex digits. Define UART_ECHO_ASCII_HEX_EN for ASCII-hex history.
module uart_echo_display_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_DIGITS = 2,
  parameter int DROP_CNT_W = 8
) (
  input  logic                          i_Clk,
  input  logic                          i_Reset,
  input  logic                          i_RX_DV,
  input  logic [7:0]                    i_RX_Byte,
  input  logic                          i_Echo_En,
  input  logic                          i_TX_Active,
  output logic                          o_TX_DV,
  output logic [7:0]                    o_TX_Byte,
  output logic [4*NUM_DIGITS-1:0]       o_Digits,
  output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count,
  output logic                          o_FIFO_Full,
  output logic                          o_FIFO_Empty,
  output logic [DROP_CNT_W-1:0]         o_Drop_Count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIG_W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    WAIT_DONE
  } state_t;

  state_t              r_State;
  state_t              w_Next_State;
  logic                w_Pop;

  logic [7:0]          r_Mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_Wr_Ptr;
  logic [PTR_W-1:0]    r_Rd_Ptr;
  logic [CNT_W-1:0]    r_Count;
  logic [DROP_CNT_W-1:0] r_Drop_Count;
  logic                r_TX_DV;
  logic [7:0]          r_TX_Byte;
  logic [DIG_W-1:0]    r_Digits;
  logic [DIG_W-1:0]    w_Digits_Next;

  logic                w_Full;
  logic                w_Empty;
  logic                w_Push_Req;
  logic                w_Push;
  logic                w_Drop;

  // Fullness is judged on the pre-edge count, so a push into a full FIFO is
  // dropped even when the transmitter pops on the same edge.
  assign w_Full     = (r_Count == CNT_W'(FIFO_DEPTH));
  assign w_Empty    = (r_Count == '0);
  assign w_Push_Req = i_RX_DV & i_Echo_En;
  assign w_Push     = w_Push_Req & ~w_Full;
  assign w_Drop     = w_Push_Req & w_Full;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_Next_State = r_State;
    w_Pop        = 1'b0;
    case (r_State)
      IDLE: begin
        if (!w_Empty && !i_TX_Active) begin
          w_Pop        = 1'b1;
          w_Next_State = WAIT_START;
        end
      end
      WAIT_START: begin
        if (i_TX_Active) w_Next_State = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!i_TX_Active) w_Next_State = IDLE;
      end
      default: w_Next_State = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) r_State <= IDLE;
    else         r_State <= w_Next_State;
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are valid, and leaving it unreset lets it map to RAM.
  always_ff @(posedge i_Clk) begin
    if (w_Push) r_Mem[r_Wr_Ptr] <= i_RX_Byte;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_Wr_Ptr     <= '0;
      r_Rd_Ptr     <= '0;
      r_Count      <= '0;
      r_Drop_Count <= '0;
      r_TX_DV      <= 1'b0;
      r_TX_Byte    <= 8'h00;
    end else begin
      if (w_Push) r_Wr_Ptr <= r_Wr_Ptr + PTR_W'(1);
      if (w_Pop)  r_Rd_Ptr <= r_Rd_Ptr + PTR_W'(1);
      case ({w_Push, w_Pop})
        2'b10:   r_Count <= r_Count + CNT_W'(1);
        2'b01:   r_Count <= r_Count - CNT_W'(1);
        default: r_Count <= r_Count;
      endcase
      if (w_Drop && (r_Drop_Count != '1)) r_Drop_Count <= r_Drop_Count + DROP_CNT_W'(1);
      r_TX_DV <= w_Pop;
      if (w_Pop) r_TX_Byte <= r_Mem[r_Rd_Ptr];
    end
  end

`ifdef UART_ECHO_ASCII_HEX_EN
  logic       w_Is_Hex;
  logic [3:0] w_Nibble;

  always_comb begin
    w_Is_Hex = 1'b0;
    w_Nibble = 4'h0;
    if (i_RX_Byte >= 8'h30 && i_RX_Byte <= 8'h39) begin
      w_Is_Hex = 1'b1;
      w_Nibble = i_RX_Byte[3:0];
    end else if ((i_RX_Byte >= 8'h41 && i_RX_Byte <= 8'h46) ||
                 (i_RX_Byte >= 8'h61 && i_RX_Byte <= 8'h66)) begin
      w_Is_Hex = 1'b1;
      w_Nibble = i_RX_Byte[3:0] + 4'd9;
    end
  end

  always_comb begin
    w_Digits_Next = r_Digits;
    if (i_RX_DV) begin
      if (i_RX_Byte == 8'h0D)  w_Digits_Next = '0;
      else if (w_Is_Hex)       w_Digits_Next = (r_Digits << 4) | DIG_W'(w_Nibble);
    end
  end
`else
  always_comb begin
    w_Digits_Next = r_Digits;
    if (i_RX_DV) w_Digits_Next = (r_Digits << 8) | DIG_W'(i_RX_Byte);
  end
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Reset) r_Digits <= '0;
    else         r_Digits <= w_Digits_Next;
  end

  assign o_TX_DV      = r_TX_DV;
  assign o_TX_Byte    = r_TX_Byte;
  assign o_Digits     = r_Digits;
  assign o_FIFO_Count = r_Count;
  assign o_FIFO_Full  = w_Full;
  assign o_FIFO_Empty = w_Empty;
  assign o_Drop_Count = r_Drop_Count;

endmodule

// File: tb/tb_uart_echo_display_ctrl.sv
// Bench for uart_echo_display_ctrl: queue-based reference model checked every cycle,
// a simple transmitter model, and directed vectors with literal expectations.
module tb_uart_echo_display_ctrl;

  localparam int DEPTH = 8;
  localparam int NDIG  = 4;
  localparam int DW    = 3;
  localparam int DIGW  = 4 * NDIG;
  localparam int CW    = $clog2(DEPTH) + 1;

`ifdef UART_ECHO_ASCII_HEX_EN
  localparam logic [15:0] EXP_A5 = 16'h0000;
`else
  localparam logic [15:0] EXP_A5 = 16'h00A5;
`endif

  logic            clk = 1'b0;
  logic            i_Reset = 1'b1;
  logic            i_RX_DV = 1'b0;
  logic [7:0]      i_RX_Byte = 8'h00;
  logic            i_Echo_En = 1'b0;
  logic            i_TX_Active;
  logic            o_TX_DV;
  logic [7:0]      o_TX_Byte;
  logic [DIGW-1:0] o_Digits;
  logic [CW-1:0]   o_FIFO_Count;
  logic            o_FIFO_Full;
  logic            o_FIFO_Empty;
  logic [DW-1:0]   o_Drop_Count;

  always #5 clk = ~clk;

  uart_echo_display_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .NUM_DIGITS (NDIG),
    .DROP_CNT_W (DW)
  ) dut (
    .i_Clk        (clk),
    .i_Reset      (i_Reset),
    .i_RX_DV      (i_RX_DV),
    .i_RX_Byte    (i_RX_Byte),
    .i_Echo_En    (i_Echo_En),
    .i_TX_Active  (i_TX_Active),
    .o_TX_DV      (o_TX_DV),
    .o_TX_Byte    (o_TX_Byte),
    .o_Digits     (o_Digits),
    .o_FIFO_Count (o_FIFO_Count),
    .o_FIFO_Full  (o_FIFO_Full),
    .o_FIFO_Empty (o_FIFO_Empty),
    .o_Drop_Count (o_Drop_Count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter model: busy for frame_len cycles after each launch strobe.
  logic       force_busy = 1'b0;
  int         busy_cnt   = 0;
  int         frame_len  = 16;
  int         n_launch   = 0;
  logic [7:0] tx_log [$];

  assign i_TX_Active = force_busy || (busy_cnt != 0);

  always @(negedge clk) begin
    if (busy_cnt != 0) busy_cnt--;
    if (o_TX_DV === 1'b1) begin
      busy_cnt = frame_len;
      n_launch++;
      tx_log.push_back(o_TX_Byte);
    end
  end

  // Reference model: byte queue, drop counter, digit history, and a
  // "frame in flight" flag that clears once busy has been seen and released.
  logic [7:0]  m_q [$];
  int          m_drop = 0;
  logic [15:0] m_digits = '0;
  bit          m_in_flight = 1'b0;
  bit          m_seen_busy = 1'b0;
  bit          m_tx_dv = 1'b0;
  logic [7:0]  m_tx_byte = 8'h00;
  bit          m_launch;
  bit          m_push_ok;
  bit          cmp_en = 1'b0;

  function automatic logic [15:0] next_digits(input logic [15:0] d, input logic [7:0] b);
`ifdef UART_ECHO_ASCII_HEX_EN
    if (b == 8'h0D) return 16'h0000;
    if (b >= 8'h30 && b <= 8'h39) return (d << 4) | 16'(b - 8'h30);
    if (b >= 8'h61 && b <= 8'h66) return (d << 4) | 16'(b - 8'h57);
    if (b >= 8'h41 && b <= 8'h46) return (d << 4) | 16'(b - 8'h37);
    return d;
`else
    return (d << 8) | 16'(b);
`endif
  endfunction

  always @(posedge clk) begin
    if (i_Reset) begin
      m_q.delete();
      m_drop      = 0;
      m_digits    = '0;
      m_in_flight = 1'b0;
      m_seen_busy = 1'b0;
      m_tx_dv     = 1'b0;
      m_tx_byte   = 8'h00;
    end else begin
      m_launch = !m_in_flight && (m_q.size() != 0) && !i_TX_Active;
      if (m_in_flight) begin
        if (!m_seen_busy) begin
          if (i_TX_Active) m_seen_busy = 1'b1;
        end else if (!i_TX_Active) begin
          m_in_flight = 1'b0;
        end
      end
      m_push_ok = i_RX_DV && i_Echo_En && (m_q.size() < DEPTH);
      if (i_RX_DV && i_Echo_En && !m_push_ok && m_drop < (1 << DW) - 1) m_drop++;
      m_tx_dv = m_launch;
      if (m_launch) begin
        m_tx_byte   = m_q.pop_front();
        m_in_flight = 1'b1;
        m_seen_busy = 1'b0;
      end
      if (m_push_ok) m_q.push_back(i_RX_Byte);
      if (i_RX_DV) m_digits = next_digits(m_digits, i_RX_Byte);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("tx_dv",   o_TX_DV,      m_tx_dv);
      check("tx_byte", o_TX_Byte,    m_tx_byte);
      check("digits",  o_Digits,     m_digits);
      check("count",   o_FIFO_Count, m_q.size());
      check("full",    o_FIFO_Full,  m_q.size() == DEPTH);
      check("empty",   o_FIFO_Empty, m_q.size() == 0);
      check("drops",   o_Drop_Count, m_drop);
    end
  end

  task automatic send(input logic [7:0] b, input logic en);
    i_RX_DV   = 1'b1;
    i_RX_Byte = b;
    i_Echo_En = en;
    @(negedge clk);
    i_RX_DV   = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (m_q.size() == 0 && !m_in_flight && !i_TX_Active) begin
        done = 1'b1;
        break;
      end
    end
    check("idle_within_budget", done, 1'b1);
  endtask

  task automatic check_log(input logic [7:0] first, input int n);
    check("log_len", tx_log.size(), n);
    for (int i = 0; i < n && i < tx_log.size(); i++)
      check($sformatf("log_byte[%0d]", i), tx_log[i], first + 8'(i));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n0;

  initial begin
    repeat (3) @(negedge clk);
    i_Reset = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;

    // Reset values
    check("rst_tx_dv",  o_TX_DV,      1'b0);
    check("rst_tx_byte", o_TX_Byte,   8'h00);
    check("rst_digits", o_Digits,     16'h0000);
    check("rst_count",  o_FIFO_Count, 0);
    check("rst_empty",  o_FIFO_Empty, 1'b1);
    check("rst_full",   o_FIFO_Full,  1'b0);
    check("rst_drops",  o_Drop_Count, 0);

    // Single byte: digits one cycle later, launch two cycles after the strobe
    frame_len = 2170;
    send(8'hA5, 1'b1);
    check("a5_digits", o_Digits, EXP_A5);
    check("a5_no_early_dv", o_TX_DV, 1'b0);
    @(negedge clk);
    check("a5_tx_dv", o_TX_DV, 1'b1);
    check("a5_tx_byte", o_TX_Byte, 8'hA5);
    wait_idle(2400);
    check("a5_single_launch", n_launch, 1);

    // Burst of 5 while busy, then in-order replay
    frame_len = 16;
    tx_log.delete();
    force_busy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) send(8'h11 + 8'(i), 1'b1);
    check("burst_count", o_FIFO_Count, 5);
    force_busy = 1'b0;
    wait_idle(500);
    check_log(8'h11, 5);

    // Overflow and saturation of the drop counter
    tx_log.delete();
    force_busy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) send(8'h20 + 8'(i), 1'b1);
    check("ovf_full", o_FIFO_Full, 1'b1);
    check("ovf_drops", o_Drop_Count, 2);
    for (int i = 0; i < 6; i++) send(8'h30 + 8'(i), 1'b1);
    check("ovf_drops_sat", o_Drop_Count, 7);
    // Push while full on the same edge as a pop: the push is dropped
    force_busy = 1'b0;
    send(8'h55, 1'b1);
    check("full_pop_push_count", o_FIFO_Count, 7);
    check("full_pop_push_dv", o_TX_DV, 1'b1);
    check("full_pop_push_byte", o_TX_Byte, 8'h20);
    wait_idle(1000);
    check_log(8'h20, 8);

    // Echo disabled: history updates, FIFO untouched, no launch
    n0 = n_launch;
    send(8'h3C, 1'b0);
`ifndef UART_ECHO_ASCII_HEX_EN
    check("noecho_digits", o_Digits[7:0], 8'h3C);
`endif
    check("noecho_empty", o_FIFO_Empty, 1'b1);
    repeat (20) @(negedge clk);
    check("noecho_no_launch", n_launch, n0);

    // Reset during WAIT_DONE with 3 bytes queued
    frame_len = 60;
    send(8'h61, 1'b1);
    repeat (6) @(negedge clk);
    send(8'h62, 1'b1);
    send(8'h63, 1'b1);
    send(8'h64, 1'b1);
    check("pre_rst_count", o_FIFO_Count, 3);
    i_Reset = 1'b1;
    @(negedge clk);
    i_Reset = 1'b0;
    check("mid_rst_tx_dv",  o_TX_DV,      1'b0);
    check("mid_rst_tx_byte", o_TX_Byte,   8'h00);
    check("mid_rst_digits", o_Digits,     16'h0000);
    check("mid_rst_count",  o_FIFO_Count, 0);
    check("mid_rst_empty",  o_FIFO_Empty, 1'b1);
    check("mid_rst_full",   o_FIFO_Full,  1'b0);
    check("mid_rst_drops",  o_Drop_Count, 0);
    n0 = n_launch;
    repeat (100) @(negedge clk);
    check("post_rst_no_launch", n_launch, n0);
    tx_log.delete();
    send(8'h77, 1'b1);
    wait_idle(500);
    check_log(8'h77, 1);

`ifdef UART_ECHO_ASCII_HEX_EN
    tx_log.delete();
    send(8'h0D, 1'b1);
    send(8'h37, 1'b1);
    send(8'h66, 1'b1);
    send(8'h47, 1'b1);
    check("ascii_7f", o_Digits, 16'h007F);
    send(8'h0D, 1'b1);
    check("ascii_cr", o_Digits, 16'h0000);
    wait_idle(1000);
    check("ascii_log_len", tx_log.size(), 5);
    if (tx_log.size() == 5) begin
      check("ascii_log0", tx_log[0], 8'h0D);
      check("ascii_log1", tx_log[1], 8'h37);
      check("ascii_log2", tx_log[2], 8'h66);
      check("ascii_log3", tx_log[3], 8'h47);
      check("ascii_log4", tx_log[4], 8'h0D);
    end
`endif

    repeat (5) @(negedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_echo_display_ctrl.md
Name: uart_echo_display_ctrl

Overview:
Glue controller between a UART receiver, a UART transmitter and a bank of hex display digits. Buffers received bytes in a parametrised FIFO and replays them to the transmitter with a busy-aware handshake, so back-to-back RX bytes are not lost. Keeps a shift history of received nibbles for NUM_DIGITS seven-segment decoders. Replaces direct RX-to-TX and RX-to-segment wiring in the top level.

Parameters:
FIFO_DEPTH, 16, echo FIFO entries; power of two, 2 to 256
NUM_DIGITS, 2, hex digits held in the display history; even, 2 to 16
DROP_CNT_W, 8, width of the saturating dropped-byte counter

Ports:
i_Clk  input  1  main clock
i_Reset  input  1  synchronous active-high reset
i_RX_DV  input  1  one-cycle strobe from UART receiver, byte valid
i_RX_Byte  input  8  received byte, valid with i_RX_DV
i_Echo_En  input  1  1 = push received bytes into echo FIFO
i_TX_Active  input  1  UART transmitter busy flag
o_TX_DV  output  1  one-cycle launch strobe to transmitter
o_TX_Byte  output  8  byte to transmit, held stable between launches
o_Digits  output  4*NUM_DIGITS  nibble history; [3:0] newest digit
o_FIFO_Count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
o_FIFO_Full  output  1  occupancy == FIFO_DEPTH
o_FIFO_Empty  output  1  occupancy == 0
o_Drop_Count  output  DROP_CNT_W  bytes dropped on full FIFO, saturating

Behaviour:
- Single clock i_Clk. i_Reset is synchronous and active-high. All state updates on the rising edge.
- Reset values: o_TX_DV=0, o_TX_Byte=0, o_Digits=0, o_FIFO_Count=0, o_FIFO_Empty=1, o_FIFO_Full=0, o_Drop_Count=0, FSM=IDLE, FIFO pointers=0.
- Reset mid-frame discards FIFO contents and history. The FSM returns to IDLE without waiting for i_TX_Active.
- Push:
  - Condition: i_RX_DV=1 and i_Echo_En=1 at edge k.
  - If pre-edge count < FIFO_DEPTH: write the byte and increment the count after edge k.
  - If the FIFO is full: drop the byte and increment o_Drop_Count unless it is at all-ones.
  - Fullness uses the pre-edge count. A push while full is dropped even if a pop occurs on the same edge.
- Pop and push on the same edge when not full: count unchanged, both take effect.
- Pointers wrap modulo FIFO_DEPTH.
- Display history, raw mode (macro undefined):
  - On every i_RX_DV, regardless of i_Echo_En, o_Digits shifts left by 8 bits.
  - The low byte becomes i_RX_Byte: [7:4]=high nibble, [3:0]=low nibble.
  - Visible after edge k.
- TX FSM states: IDLE, WAIT_START, WAIT_DONE.
  - IDLE: if FIFO not empty and i_TX_Active=0, pop the head, load o_TX_Byte, assert o_TX_DV for exactly one cycle, go to WAIT_START.
  - WAIT_START: wait for i_TX_Active=1, then go to WAIT_DONE. There is no timeout; the transmitter must assert busy within a few cycles.
  - WAIT_DONE: wait for i_TX_Active=0, then go to IDLE.
- Latency: a byte pushed at edge k into an empty FIFO with an idle transmitter gives o_TX_DV high in the cycle after edge k+1, i.e. 2 cycles.
- Bytes are launched in arrival order. No launch occurs while i_TX_Active=1.
- Deasserting i_Echo_En does not flush the FIFO; bytes already queued are still sent.

Optional Feature:
Macro UART_ECHO_ASCII_HEX_EN.
- Defined: history shifts left by 4 bits per received byte that is an ASCII hex character ('0'-'9', 'a'-'f', 'A'-'F'), with the nibble equal to its value. All other bytes leave o_Digits unchanged. The byte 0x0D (CR) clears o_Digits to 0. FIFO and echo behaviour are unchanged.
- Undefined: raw mode as above, with no ASCII decode logic synthesised.

Test Plan:
- Reset, then a single RX byte 0xA5 with i_Echo_En=1 and i_TX_Active=0: o_Digits=0x00A5 one cycle later; o_TX_DV pulses 2 cycles after i_RX_DV with o_TX_Byte=0xA5. Model i_TX_Active high for 2170 cycles; no second launch.
- Burst of 5 bytes 0x11..0x15 one cycle apart while the transmitter is busy: o_FIFO_Count reaches 5; bytes transmitted in order 0x11..0x15, one o_TX_DV per frame.
- FIFO_DEPTH=4 with i_TX_Active held high: send 6 bytes. Expect o_FIFO_Full=1, o_Drop_Count=2, then 4 bytes echoed once busy is released. Separately, preload the counter path to all-ones and confirm it saturates.
- i_Echo_En=0, send 0x3C: o_Digits low byte=0x3C; o_FIFO_Empty stays 1; no o_TX_DV.
- Assert i_Reset during WAIT_DONE with 3 bytes queued: all outputs at reset values next cycle. After release, no launch until a new byte arrives.
- With UART_ECHO_ASCII_HEX_EN and NUM_DIGITS=2, send '7','f','G': o_Digits=0x7F. Then send 0x0D: o_Digits=0x00; all four bytes echoed.
